int_divide_unit: RTL and testbench

Iterative integer divide unit for the RV32 execution stage. It executes the four `div_operation_t` operations (DIV, DIVU, REM, REMU) at a parametrised data width, producing one quotient bit per cycle. RISC-V divide-by-zero and signed-overflow cases take a single-cycle fast path. It sits beside the multiply unit behind the issue logic, with a valid/ready handshake on both input and output and a flush input for pipeline kills.

---
 rtl/rv32_instructions_pkg.sv | 27 ++
 rtl/div_restoring_step.sv | 25 ++
 rtl/int_divide_unit.sv | 125 ++++++++++++
 tb/tb_int_divide_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_instructions_pkg.sv
// Shared RV32 execution-stage types: divide operation encoding and divider FSM states.
package rv32_instructions_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_operation_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREPARE = 3'd1,
    DIVIDE  = 3'd2,
    RESTORE = 3'd3,
    DONE    = 3'd4
  } div_fsm_state_t;

  function automatic logic is_signed_op(input div_operation_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input div_operation_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Zero latency; no handshake, the parent FSM sequences the steps.
module div_restoring_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic                  quotient_bit
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH+1:0] diff;
  logic                  unused_diff_msb;

  assign shifted = {rem_in, dividend_bit};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};

  // Top bit of the widened difference is the borrow; either kept value fits in DATA_WIDTH bits.
  assign quotient_bit    = ~diff[DATA_WIDTH+1];
  assign rem_out         = quotient_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  assign unused_diff_msb = diff[DATA_WIDTH];

endmodule

// File: rtl/int_divide_unit.sv
// Iterative RV32 divider (DIV/DIVU/REM/REMU), one quotient bit per cycle; DATA_WIDTH+3 cycles, 1 for x/0 and overflow.
// Single operation in flight: ready_o only in IDLE, result held in DONE until ready_i; flush_i discards everything.
module int_divide_unit
  import rv32_instructions_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  div_operation_t        operation_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  div_by_zero_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  div_fsm_state_t        state;
  div_operation_t        op_q;
  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  quot_neg_q;
  logic                  rem_neg_q;

  logic                  div_zero;
  logic                  signed_ovf;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_quot;
  logic [DATA_WIDTH-1:0] quot_fixed;
  logic [DATA_WIDTH-1:0] rem_fixed;

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  assign div_zero   = (divisor_i == '0);
  assign signed_ovf = is_signed_op(operation_i)
                      && (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                      && (divisor_i == '1);

  // The quotient is shifted into the dividend register as its bits are consumed.
  div_restoring_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (dividend_q[DATA_WIDTH-1]),
    .divisor      (divisor_q),
    .rem_out      (step_rem),
    .quotient_bit (step_quot)
  );

  assign quot_fixed = quot_neg_q ? -dividend_q : dividend_q;
  assign rem_fixed  = rem_neg_q  ? -rem_q      : rem_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      op_q          <= DIV;
      dividend_q    <= '0;
      divisor_q     <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      quot_neg_q    <= 1'b0;
      rem_neg_q     <= 1'b0;
      result_o      <= '0;
      div_by_zero_o <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            op_q          <= operation_i;
            dividend_q    <= dividend_i;
            divisor_q     <= divisor_i;
            div_by_zero_o <= div_zero;
            if (div_zero) begin
              result_o <= is_rem_op(operation_i) ? dividend_i : '1;
              state    <= DONE;
            end else if (signed_ovf) begin
              result_o <= is_rem_op(operation_i) ? '0 : dividend_i;
              state    <= DONE;
            end else begin
              state <= PREPARE;
            end
          end
        end
        PREPARE: begin
          if (is_signed_op(op_q)) begin
            dividend_q <= dividend_q[DATA_WIDTH-1] ? -dividend_q : dividend_q;
            divisor_q  <= divisor_q[DATA_WIDTH-1]  ? -divisor_q  : divisor_q;
          end
          quot_neg_q <= is_signed_op(op_q) && (dividend_q[DATA_WIDTH-1] ^ divisor_q[DATA_WIDTH-1]);
          rem_neg_q  <= is_signed_op(op_q) && dividend_q[DATA_WIDTH-1];
          rem_q      <= '0;
          cnt_q      <= CNT_W'(DATA_WIDTH - 1);
          state      <= DIVIDE;
        end
        DIVIDE: begin
          rem_q      <= step_rem;
          dividend_q <= {dividend_q[DATA_WIDTH-2:0], step_quot};
          if (cnt_q == '0) begin
            state <= RESTORE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESTORE: begin
          result_o <= is_rem_op(op_q) ? rem_fixed : quot_fixed;
          state    <= DONE;
        end
        DONE: begin
          if (ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_divide_unit.sv
// Directed checks of the divider at 32 and 8 bits, plus a small randomized sweep at 8 bits.
module tb_int_divide_unit;
  import rv32_instructions_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic           flush32 = 0, valid32 = 0, ready32, out_valid32, out_ready32 = 0, dbz32;
  div_operation_t op32 = DIV;
  logic [31:0]    dvd32 = '0, dsr32 = '0, res32;

  logic           flush8 = 0, valid8 = 0, ready8, out_valid8, out_ready8 = 0, dbz8;
  div_operation_t op8 = DIV;
  logic [7:0]     dvd8 = '0, dsr8 = '0, res8;

  int_divide_unit #(.DATA_WIDTH(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush32), .valid_i(valid32), .ready_o(ready32),
    .operation_i(op32), .dividend_i(dvd32), .divisor_i(dsr32), .valid_o(out_valid32),
    .ready_i(out_ready32), .result_o(res32), .div_by_zero_o(dbz32)
  );

  int_divide_unit #(.DATA_WIDTH(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush8), .valid_i(valid8), .ready_o(ready8),
    .operation_i(op8), .dividend_i(dvd8), .divisor_i(dsr8), .valid_o(out_valid8),
    .ready_i(out_ready8), .result_o(res8), .div_by_zero_o(dbz8)
  );

  // Issue one op, measure latency (accept edge counts as 1, -1 on timeout), then consume the result.
  task automatic run32(input div_operation_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dbz, output int lat);
    @(negedge clk); op32 = op; dvd32 = a; dsr32 = b; valid32 = 1;
    @(posedge clk); #1 valid32 = 0;
    lat = 1;
    @(negedge clk);
    while (!out_valid32 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    if (!out_valid32) lat = -1;
    res = res32; dbz = dbz32;
    out_ready32 = 1;
    @(posedge clk); #1 out_ready32 = 0;
  endtask

  task automatic run8(input div_operation_t op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] res, output logic dbz, output int lat);
    @(negedge clk); op8 = op; dvd8 = a; dsr8 = b; valid8 = 1;
    @(posedge clk); #1 valid8 = 0;
    lat = 1;
    @(negedge clk);
    while (!out_valid8 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    if (!out_valid8) lat = -1;
    res = res8; dbz = dbz8;
    out_ready8 = 1;
    @(posedge clk); #1 out_ready8 = 0;
  endtask

  function automatic logic [7:0] model8(input div_operation_t op, input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0] sa, sb;
    sa = a; sb = b;
    if (b == 8'h00) return (op == REM || op == REMU) ? a : 8'hFF;
    if ((op == DIV || op == REM) && a == 8'h80 && b == 8'hFF) return (op == DIV) ? 8'h80 : 8'h00;
    case (op)
      DIV:     return 8'(sa / sb);
      REM:     return 8'(sa % sb);
      DIVU:    return a / b;
      default: return a % b;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ready32 !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready32); else passed++;
    total++; if (out_valid32 !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid32); else passed++;
    total++; if (res32 !== 32'h0) $display("FAIL reset_result got %h exp 0", res32); else passed++;
    total++; if (dbz32 !== 1'b0) $display("FAIL reset_dbz got %b exp 0", dbz32); else passed++;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [31:0] r; logic z; int lat;
    run32(DIV, 32'hFFFFFFF9, 32'h2, r, z, lat);
    total++; if (r !== 32'hFFFFFFFD) $display("FAIL div_m7_2 got %h exp fffffffd", r); else passed++;
    total++; if (lat !== 35) $display("FAIL div_m7_2_latency got %0d exp 35", lat); else passed++;
    total++; if (z !== 1'b0) $display("FAIL div_m7_2_dbz got %b exp 0", z); else passed++;
    run32(REM, 32'hFFFFFFF9, 32'h2, r, z, lat);
    total++; if (r !== 32'hFFFFFFFF) $display("FAIL rem_m7_2 got %h exp ffffffff", r); else passed++;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; logic z; int lat;
    run32(DIVU, 32'hFFFFFFFF, 32'h3, r, z, lat);
    total++; if (r !== 32'h55555555) $display("FAIL divu_max_3 got %h exp 55555555", r); else passed++;
    run32(REMU, 32'd100, 32'd7, r, z, lat);
    total++; if (r !== 32'd2) $display("FAIL remu_100_7 got %h exp 2", r); else passed++;
    total++; if (lat !== 35) $display("FAIL remu_100_7_latency got %0d exp 35", lat); else passed++;
  endtask

  task automatic test_special();
    logic [31:0] r; logic z; int lat;
    run32(DIV, 32'd5, 32'd0, r, z, lat);
    total++; if (r !== 32'hFFFFFFFF) $display("FAIL div_5_0 got %h exp ffffffff", r); else passed++;
    total++; if (z !== 1'b1) $display("FAIL div_5_0_dbz got %b exp 1", z); else passed++;
    total++; if (lat !== 1) $display("FAIL div_5_0_latency got %0d exp 1", lat); else passed++;
    run32(REMU, 32'd5, 32'd0, r, z, lat);
    total++; if (r !== 32'd5) $display("FAIL remu_5_0 got %h exp 5", r); else passed++;
    total++; if (z !== 1'b1) $display("FAIL remu_5_0_dbz got %b exp 1", z); else passed++;
    run32(DIV, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
    total++; if (r !== 32'h80000000) $display("FAIL div_ovf got %h exp 80000000", r); else passed++;
    total++; if (lat !== 1) $display("FAIL div_ovf_latency got %0d exp 1", lat); else passed++;
    total++; if (z !== 1'b0) $display("FAIL div_ovf_dbz got %b exp 0", z); else passed++;
    run32(REM, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
    total++; if (r !== 32'h0) $display("FAIL rem_ovf got %h exp 0", r); else passed++;
  endtask

  task automatic test_hold();
    int waited = 0;
    bit bad = 0;
    @(negedge clk); op32 = DIVU; dvd32 = 32'd100; dsr32 = 32'd7; valid32 = 1;
    @(posedge clk); #1 valid32 = 0;
    @(negedge clk);
    while (!out_valid32 && waited < 100) begin @(negedge clk); waited++; end
    total++; if (out_valid32 !== 1'b1) $display("FAIL hold_valid_timeout got %b exp 1", out_valid32); else passed++;
    for (int i = 0; i < 10; i++) begin
      if (res32 !== 32'd14 || ready32 !== 1'b0 || out_valid32 !== 1'b1) bad = 1;
      @(negedge clk);
    end
    total++; if (bad) $display("FAIL hold_stable last res %h ready %b valid %b exp 0000000e 0 1", res32, ready32, out_valid32); else passed++;
    out_ready32 = 1;
    @(posedge clk); #1 out_ready32 = 0;
    @(negedge clk);
    total++; if (ready32 !== 1'b1) $display("FAIL hold_release_ready got %b exp 1", ready32); else passed++;
  endtask

  task automatic test_flush();
    bit seen = 0;
    @(negedge clk); op32 = DIV; dvd32 = 32'hFFFFFFF9; dsr32 = 32'h2; valid32 = 1;
    @(posedge clk); #1 valid32 = 0;
    repeat (12) @(posedge clk);
    @(negedge clk); flush32 = 1;
    @(posedge clk); #1 flush32 = 0;
    @(negedge clk);
    total++; if (ready32 !== 1'b1) $display("FAIL flush_ready got %b exp 1", ready32); else passed++;
    total++; if (out_valid32 !== 1'b0) $display("FAIL flush_valid got %b exp 0", out_valid32); else passed++;
    // Flush must also win over an input transfer in the same cycle.
    valid32 = 1; flush32 = 1;
    @(posedge clk); #1 valid32 = 0; flush32 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid32 !== 1'b0 || ready32 !== 1'b1) seen = 1;
    end
    total++; if (seen) $display("FAIL flush_no_result valid %b ready %b exp 0 1", out_valid32, ready32); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic z; int lat;
    run32(DIVU, 32'd1000, 32'd10, r, z, lat);
    @(negedge clk);
    total++; if (ready32 !== 1'b1) $display("FAIL b2b_ready got %b exp 1", ready32); else passed++;
    run32(DIV, 32'd7, 32'hFFFFFFFE, r, z, lat);
    total++; if (r !== 32'hFFFFFFFD) $display("FAIL b2b_second got %h exp fffffffd", r); else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); op32 = DIVU; dvd32 = 32'hFFFFFFFF; dsr32 = 32'd3; valid32 = 1;
    @(posedge clk); #1 valid32 = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    total++; if (ready32 !== 1'b1 || out_valid32 !== 1'b0) $display("FAIL midreset_hs ready %b valid %b exp 1 0", ready32, out_valid32); else passed++;
    total++; if (res32 !== 32'h0) $display("FAIL midreset_result got %h exp 0", res32); else passed++;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_width8();
    logic [7:0] r, a, b, exp_r; logic z; int lat, exp_lat;
    div_operation_t op;
    bit bad = 0;
    run8(DIV, 8'h80, 8'h03, r, z, lat);
    total++; if (r !== 8'hD6) $display("FAIL w8_div_80_3 got %h exp d6", r); else passed++;
    total++; if (lat !== 11) $display("FAIL w8_latency got %0d exp 11", lat); else passed++;
    for (int i = 0; i < 60; i++) begin
      op = div_operation_t'(2'($urandom_range(0, 3)));
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 9 == 0) b = 8'h00;
      if (i % 11 == 5) begin a = 8'h80; b = 8'hFF; end
      run8(op, a, b, r, z, lat);
      exp_r = model8(op, a, b);
      exp_lat = (b == 8'h00 || ((op == DIV || op == REM) && a == 8'h80 && b == 8'hFF)) ? 1 : 11;
      if (r !== exp_r || z !== (b == 8'h00) || lat !== exp_lat) begin
        bad = 1;
        $display("FAIL w8_sweep op %0d a %h b %h got %h/%b/%0d exp %h/%b/%0d",
                 op, a, b, r, z, lat, exp_r, (b == 8'h00), exp_lat);
      end
    end
    total++; if (bad) $display("FAIL w8_sweep_summary mismatches seen got 1 exp 0"); else passed++;
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_special();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
